// File: rtl/pipes_pkg.sv
// rtl/pipes_pkg.sv - shared pipeline types for the execute/memory/writeback stages
package pipes;

    localparam logic [5:0] F6_LW = 6'b100011;
    localparam logic [5:0] F6_SW = 6'b101011;

    typedef struct packed {
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu_result;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] instruction;
    } execute_data_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] instruction;
    } memory_data_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

    // Stores and misaligned accesses never write back; neither does anything targeting r0.
    function automatic memory_data_t make_mem_data(execute_data_t ex, logic [31:0] load_data,
                                                   logic misaligned);
        memory_data_t md;
        md.wa          = ex.reg_dst ? ex.rd : ex.rt;
        md.wd          = (ex.mem_to_reg && !misaligned) ? load_data : ex.alu_result;
        md.reg_write   = ex.reg_write && !ex.mem_write && !misaligned && (md.wa != 5'd0);
        md.pc          = ex.pc;
        md.instruction = ex.instruction;
        return md;
    endfunction

endpackage

// File: rtl/memory_bus_fsm.sv
// rtl/memory_bus_fsm.sv - data-bus request/response sequencer for the MEM stage
module mem_bus_fsm
    import pipes::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic i_start,
    input  logic i_addr_ok,
    input  logic i_data_ok,
    output logic o_idle,
    output logic o_dreq_valid,
    output logic o_fin
);

    mem_state_t r_state;
    mem_state_t w_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // data_ok alone in REQ is taken as an accepted-and-completed request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_next = REQ;
            REQ: begin
                if (i_data_ok)      w_next = DONE;
                else if (i_addr_ok) w_next = WAIT;
            end
            WAIT: if (i_data_ok) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_idle       = (r_state == IDLE);
        o_dreq_valid = (r_state == REQ);
        o_fin        = ((r_state == REQ) || (r_state == WAIT)) && i_data_ok;
    end

endmodule

// File: rtl/memory.sv
// rtl/memory.sv - MIPS MEM stage: LW/SW over a request/response data bus, pass-through otherwise
module memory
    import pipes::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  execute_data_t       execute_data,
    input  logic [DATA_W-1:0]   store_data,
    output logic                in_ready,
    output logic                stall,
    output logic                dreq_valid,
    output logic                dreq_write,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [DATA_W-1:0]   dreq_wdata,
    output logic [3:0]          dreq_strobe,
    input  logic                dresp_addr_ok,
    input  logic                dresp_data_ok,
    input  logic [DATA_W-1:0]   dresp_data,
    output memory_data_t        memory_data,
    output logic                out_valid,
    output logic                misalign
);

    logic          w_idle;
    logic          w_fin;
    logic          w_accept;
    logic          w_is_mem;
    logic          w_misaligned;
    logic          w_start;
    logic          w_retire_now;
    execute_data_t r_ex;
    logic [DATA_W-1:0] r_store;
    memory_data_t  r_out;
    logic          r_out_valid;
    logic          r_misalign;

    assign w_accept     = in_valid & w_idle;
    assign w_is_mem     = execute_data.mem_to_reg | execute_data.mem_write;
    assign w_misaligned = w_is_mem & (execute_data.alu_result[1:0] != 2'b00);
    assign w_start      = w_accept & w_is_mem & ~w_misaligned;
    assign w_retire_now = w_accept & ~w_start;

    mem_bus_fsm u_fsm (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (w_start),
        .i_addr_ok    (dresp_addr_ok),
        .i_data_ok    (dresp_data_ok),
        .o_idle       (w_idle),
        .o_dreq_valid (dreq_valid),
        .o_fin        (w_fin)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ex    <= '0;
            r_store <= '0;
        end else if (w_accept) begin
            r_ex    <= execute_data;
            r_store <= store_data;
        end
    end

    // Bus completions load straight from dresp_data, so out_valid rises the cycle after data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_out_valid <= w_retire_now | w_fin;
            r_misalign  <= w_accept & w_misaligned;
            if (w_fin)
                r_out <= make_mem_data(r_ex, dresp_data, 1'b0);
            else if (w_retire_now)
                r_out <= make_mem_data(execute_data, '0, w_misaligned);
        end
    end

    assign in_ready    = w_idle;
    assign stall       = ~w_idle;
    assign dreq_write  = r_ex.mem_write;
    assign dreq_addr   = {r_ex.alu_result[ADDR_W-1:2], 2'b00};
    assign dreq_wdata  = r_store;
    assign dreq_strobe = {4{r_ex.mem_write}};
    assign memory_data = r_out;
    assign out_valid   = r_out_valid;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for the MEM stage
module tb_memory;
    import pipes::*;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    execute_data_t execute_data;
    logic [31:0]   store_data;
    logic          in_ready;
    logic          stall;
    logic          dreq_valid;
    logic          dreq_write;
    logic [31:0]   dreq_addr;
    logic [31:0]   dreq_wdata;
    logic [3:0]    dreq_strobe;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [31:0]   dresp_data;
    memory_data_t  memory_data;
    logic          out_valid;
    logic          misalign;

    int checks = 0;
    int errors = 0;

    memory #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .execute_data  (execute_data),
        .store_data    (store_data),
        .in_ready      (in_ready),
        .stall         (stall),
        .dreq_valid    (dreq_valid),
        .dreq_write    (dreq_write),
        .dreq_addr     (dreq_addr),
        .dreq_wdata    (dreq_wdata),
        .dreq_strobe   (dreq_strobe),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .memory_data   (memory_data),
        .out_valid     (out_valid),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic execute_data_t mk(input logic rw, input logic rdst, input logic m2r,
                                         input logic mw, input logic [31:0] alu,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [31:0] pc, input logic [31:0] ins);
        execute_data_t e;
        e.reg_write   = rw;
        e.reg_dst     = rdst;
        e.mem_to_reg  = m2r;
        e.mem_write   = mw;
        e.alu_result  = alu;
        e.rt          = rt;
        e.rd          = rd;
        e.pc          = pc;
        e.instruction = ins;
        return e;
    endfunction

    initial begin
        resetn        = 1'b0;
        in_valid      = 1'b0;
        execute_data  = '0;
        store_data    = 32'h0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   1);
        check("rst_stall",      32'(stall),      0);
        check("rst_dreq_valid", 32'(dreq_valid), 0);
        check("rst_out_valid",  32'(out_valid),  0);
        check("rst_misalign",   32'(misalign),   0);
        check("rst_md_zero",    32'(memory_data === '0), 1);
        resetn = 1'b1;

        // two back-to-back ADDs retire one per cycle
        execute_data = mk(1, 1, 0, 0, 32'h7, 5'd2, 5'd3, 32'h100, 32'h0043_1820);
        in_valid = 1'b1;
        @(negedge clk);
        check("add_out_valid",  32'(out_valid),             1);
        check("add_wa",         32'(memory_data.wa),        3);
        check("add_wd",         memory_data.wd,             32'h7);
        check("add_reg_write",  32'(memory_data.reg_write), 1);
        check("add_pc",         memory_data.pc,             32'h100);
        check("add_no_dreq",    32'(dreq_valid),            0);
        check("add_in_ready",   32'(in_ready),              1);
        execute_data = mk(1, 1, 0, 0, 32'h9, 5'd2, 5'd4, 32'h104, 32'h0043_2020);
        @(negedge clk);
        check("add2_out_valid", 32'(out_valid),      1);
        check("add2_wa",        32'(memory_data.wa), 4);
        check("add2_wd",        memory_data.wd,      32'h9);
        in_valid = 1'b0;
        @(negedge clk);
        check("add2_pulse_end", 32'(out_valid),      0);
        check("add2_wd_hold",   memory_data.wd,      32'h9);

        // LW with immediate addr_ok+data_ok
        execute_data = mk(1, 0, 1, 0, 32'h10, 5'd5, 5'd0, 32'h108, {F6_LW, 26'h0010});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("lw_dreq_valid", 32'(dreq_valid),  1);
        check("lw_addr",       dreq_addr,        32'h10);
        check("lw_strobe",     32'(dreq_strobe), 0);
        check("lw_write",      32'(dreq_write),  0);
        check("lw_stall1",     32'(stall),       1);
        check("lw_no_out",     32'(out_valid),   0);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 32'hDEAD_BEEF;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;
        check("lw_out_valid", 32'(out_valid),             1);
        check("lw_wd",        memory_data.wd,             32'hDEAD_BEEF);
        check("lw_wa",        32'(memory_data.wa),        5);
        check("lw_reg_write", 32'(memory_data.reg_write), 1);
        check("lw_stall2",    32'(stall),                 1);
        check("lw_dreq_off",  32'(dreq_valid),            0);
        @(negedge clk);
        check("lw_stall_end", 32'(stall),     0);
        check("lw_pulse_end", 32'(out_valid), 0);

        // data_ok while idle is ignored
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check("idle_dok_out", 32'(out_valid), 0);
        check("idle_dok_rdy", 32'(in_ready),  1);

        // SW: addr_ok in the third REQ cycle, data_ok two cycles later
        execute_data = mk(1, 0, 0, 1, 32'h20, 5'd7, 5'd0, 32'h10C, {F6_SW, 26'h0020});
        store_data = 32'h1234;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        execute_data = mk(1, 1, 0, 0, 32'h44, 5'd1, 5'd1, 32'h0, 32'h0);
        store_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            check("sw_dreq_valid", 32'(dreq_valid),  1);
            check("sw_addr",       dreq_addr,        32'h20);
            check("sw_wdata",      dreq_wdata,       32'h1234);
            check("sw_strobe",     32'(dreq_strobe), 32'hF);
            check("sw_write",      32'(dreq_write),  1);
            check("sw_stall",      32'(stall),       1);
            if (i == 2) dresp_addr_ok = 1'b1;
            @(negedge clk);
        end
        dresp_addr_ok = 1'b0;
        check("sw_wait_dreq",  32'(dreq_valid), 0);
        check("sw_wait_stall", 32'(stall),      1);
        check("sw_wait_out",   32'(out_valid),  0);
        @(negedge clk);
        check("sw_wait2_stall", 32'(stall), 1);
        dresp_data_ok = 1'b1;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check("sw_out_valid", 32'(out_valid),             1);
        check("sw_reg_write", 32'(memory_data.reg_write), 0);
        check("sw_wa",        32'(memory_data.wa),        7);
        check("sw_stall_out", 32'(stall),                 1);
        @(negedge clk);
        check("sw_stall_end", 32'(stall),     0);
        check("sw_pulse_end", 32'(out_valid), 0);

        // misaligned LW retires without a bus access
        execute_data = mk(1, 0, 1, 0, 32'h13, 5'd6, 5'd0, 32'h110, {F6_LW, 26'h0013});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mis_out_valid", 32'(out_valid),             1);
        check("mis_flag",      32'(misalign),              1);
        check("mis_reg_write", 32'(memory_data.reg_write), 0);
        check("mis_no_dreq",   32'(dreq_valid),            0);
        check("mis_in_ready",  32'(in_ready),              1);
        @(negedge clk);
        check("mis_flag_end",  32'(misalign),   0);
        check("mis_no_dreq2",  32'(dreq_valid), 0);

        // ADDI to r0 never writes back
        execute_data = mk(1, 0, 0, 0, 32'h5, 5'd0, 5'd0, 32'h114, 32'h2000_0005);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("r0_out_valid", 32'(out_valid),             1);
        check("r0_reg_write", 32'(memory_data.reg_write), 0);
        check("r0_wd",        memory_data.wd,             32'h5);

        // reset while waiting for data_ok
        execute_data = mk(1, 0, 1, 0, 32'h40, 5'd8, 5'd0, 32'h118, {F6_LW, 26'h0040});
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dresp_addr_ok = 1'b1;
        @(negedge clk);
        dresp_addr_ok = 1'b0;
        check("rm_wait_dreq",  32'(dreq_valid), 0);
        check("rm_wait_stall", 32'(stall),      1);
        #2 resetn = 1'b0;
        #1;
        check("rm_in_ready", 32'(in_ready),           1);
        check("rm_stall",    32'(stall),              0);
        check("rm_out",      32'(out_valid),          0);
        check("rm_md_zero",  32'(memory_data === '0), 1);
        @(negedge clk);
        resetn = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h0BAD;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        check("rm_late_dok_out", 32'(out_valid), 0);
        check("rm_late_dok_rdy", 32'(in_ready),  1);
        execute_data = mk(1, 1, 0, 0, 32'h55, 5'd1, 5'd9, 32'h11C, 32'h0022_4820);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_add_out", 32'(out_valid),             1);
        check("rm_add_wa",  32'(memory_data.wa),        9);
        check("rm_add_wd",  memory_data.wd,             32'h55);
        check("rm_add_rw",  32'(memory_data.reg_write), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
